ascon_ctrl_fsm_param: RTL and testbench

- Parametrised Ascon AEAD control FSM, successor to the fixed-round controller.
- Owns its own round counter, so no external round input.
- Handles a variable number of associated-data (DA) and plaintext/ciphertext (TC) blocks, empty-DA skip, and a ready/valid block handshake.
- Drives the permutation datapath: state register enable, input mux, begin/end XOR bypass, and cipher/tag register enables.

---
 rtl/ascon_pack.sv | 39 +++
 rtl/ascon_round_counter.sv | 37 +++
 rtl/ascon_ctrl_fsm_param.sv | 209 ++++++++++++++++++++
 tb/tb_ascon_ctrl_fsm_param.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared types and constants for the parametrised Ascon AEAD control FSM.
package ascon_pack;

    localparam int unsigned ASCON_ROUNDS_MAX = 12;
    localparam int unsigned PA_DEFAULT       = 12;
    localparam int unsigned PB_DEFAULT       = 6;
    localparam int unsigned CNT_W            = 4;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StWaitDa,
        StDa,
        StWaitTc,
        StTc,
        StFinal,
        StDone
    } ascon_state_e;

    typedef enum logic [1:0] {
        XbNone = 2'b00,
        XbData = 2'b01,
        XbKey  = 2'b10,
        XbBoth = 2'b11
    } xor_begin_t;

    typedef enum logic [1:0] {
        XeNone   = 2'b00,
        XeKey    = 2'b01,
        XeDomain = 2'b10,
        XeBoth   = 2'b11
    } xor_end_t;

    // First round index of a phase that runs n rounds ending at index 11.
    function automatic logic [CNT_W-1:0] round_start(input int unsigned n);
        return CNT_W'(ASCON_ROUNDS_MAX - n);
    endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// Round counter: loads the first round index of a phase, steps once per cycle,
// and flags the final round (index 11).
module ascon_round_counter
    import ascon_pack::*;
(
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] rounds_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = round_start(int'(rounds_i));
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CNT_W'(ASCON_ROUNDS_MAX - 1));

endmodule

// File: rtl/ascon_ctrl_fsm_param.sv
// Parametrised Ascon AEAD control FSM with internal round counter and block handshake.
// Define ASCON_DECRYPT_EN to drive input_mode_o from the latched decrypt flag.
module ascon_ctrl_fsm_param
    import ascon_pack::*;
#(
    parameter int unsigned PA_ROUNDS = PA_DEFAULT,
    parameter int unsigned PB_ROUNDS = PB_DEFAULT,
    parameter int unsigned ROUND_W   = 4
) (
    input  logic               clock_i,
    input  logic               resetb_i,
    input  logic               start_i,
    input  logic               ad_empty_i,
    input  logic               decrypt_i,
    input  logic               data_valid_i,
    input  logic               last_i,
    output logic               data_ready_o,
    output logic [ROUND_W-1:0] round_o,
    output logic               init_a_o,
    output logic               init_b_o,
    output logic               en_reg_state_o,
    output logic [1:0]         bypass_xor_begin_o,
    output logic [1:0]         bypass_xor_end_o,
    output logic               en_reg_cipher_o,
    output logic               cipher_valid_o,
    output logic               en_reg_tag_o,
    output logic               input_mode_o,
    output logic               busy_o,
    output logic               end_o
);

    if (PA_ROUNDS < 1 || PA_ROUNDS > ASCON_ROUNDS_MAX) begin : g_bad_pa
        $error("PA_ROUNDS must be in 1..12");
    end
    if (PB_ROUNDS < 1 || PB_ROUNDS > ASCON_ROUNDS_MAX) begin : g_bad_pb
        $error("PB_ROUNDS must be in 1..12");
    end

    localparam logic [CNT_W-1:0] PaStart = round_start(PA_ROUNDS);
    localparam logic [CNT_W-1:0] PbStart = round_start(PB_ROUNDS);
    localparam logic [CNT_W-1:0] PaRounds = CNT_W'(PA_ROUNDS);
    localparam logic [CNT_W-1:0] PbRounds = CNT_W'(PB_ROUNDS);

    ascon_state_e state_d, state_q;
    logic         ad_empty_d, ad_empty_q;
    logic         last_blk_d, last_blk_q;
    logic         cipher_valid_d, cipher_valid_q;

    logic             cnt_load, cnt_inc, cnt_last;
    logic [CNT_W-1:0] cnt_rounds, cnt;
    logic             computing, first_pa, first_pb;
    xor_begin_t       xor_begin;
    xor_end_t         xor_end;
    logic             en_cipher;

    ascon_round_counter u_round_counter (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .load_i   (cnt_load),
        .rounds_i (cnt_rounds),
        .inc_i    (cnt_inc),
        .cnt_o    (cnt),
        .last_o   (cnt_last)
    );

    assign first_pa = (cnt == PaStart);
    assign first_pb = (cnt == PbStart);

    always_comb begin
        state_d        = state_q;
        ad_empty_d     = ad_empty_q;
        last_blk_d     = last_blk_q;
        cnt_load       = 1'b0;
        cnt_rounds     = PbRounds;
        cnt_inc        = 1'b0;
        computing      = 1'b0;
        data_ready_o   = 1'b0;
        init_a_o       = 1'b0;
        init_b_o       = 1'b0;
        en_reg_state_o = 1'b0;
        xor_begin      = XbNone;
        xor_end        = XeNone;
        en_cipher      = 1'b0;
        en_reg_tag_o   = 1'b0;
        end_o          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StInit;
                    ad_empty_d = ad_empty_i;
                    cnt_load   = 1'b1;
                    cnt_rounds = PaRounds;
                end
            end
            StInit: begin
                computing = 1'b1;
                init_a_o  = first_pa;
                init_b_o  = !first_pa;
                if (cnt_last) begin
                    xor_end = ad_empty_q ? XeBoth : XeKey;
                    state_d = ad_empty_q ? StWaitTc : StWaitDa;
                end
            end
            StWaitDa: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    state_d    = StDa;
                    last_blk_d = last_i;
                    cnt_load   = 1'b1;
                end
            end
            StDa: begin
                computing = 1'b1;
                init_b_o  = 1'b1;
                if (first_pb) xor_begin = XbData;
                if (cnt_last) begin
                    if (last_blk_q) xor_end = XeDomain;
                    state_d = last_blk_q ? StWaitTc : StWaitDa;
                end
            end
            StWaitTc: begin
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    // The last block skips its PB permutation and goes straight to finalisation.
                    state_d    = last_i ? StFinal : StTc;
                    cnt_load   = 1'b1;
                    cnt_rounds = last_i ? PaRounds : PbRounds;
                end
            end
            StTc: begin
                computing = 1'b1;
                init_b_o  = 1'b1;
                if (first_pb) begin
                    xor_begin = XbData;
                    en_cipher = 1'b1;
                end
                if (cnt_last) state_d = StWaitTc;
            end
            StFinal: begin
                computing = 1'b1;
                init_b_o  = 1'b1;
                if (first_pa) begin
                    xor_begin = XbBoth;
                    en_cipher = 1'b1;
                end
                if (cnt_last) begin
                    xor_end      = XeKey;
                    en_reg_tag_o = 1'b1;
                    state_d      = StDone;
                end
            end
            StDone: begin
                end_o   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (computing) begin
            en_reg_state_o = 1'b1;
            cnt_inc        = !cnt_last;
        end
    end

    assign cipher_valid_d = en_cipher;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q        <= StIdle;
            ad_empty_q     <= 1'b0;
            last_blk_q     <= 1'b0;
            cipher_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ad_empty_q     <= ad_empty_d;
            last_blk_q     <= last_blk_d;
            cipher_valid_q <= cipher_valid_d;
        end
    end

`ifdef ASCON_DECRYPT_EN
    logic decrypt_d, decrypt_q;

    assign decrypt_d = (state_q == StIdle && start_i) ? decrypt_i : decrypt_q;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            decrypt_q <= 1'b0;
        end else begin
            decrypt_q <= decrypt_d;
        end
    end

    assign input_mode_o = decrypt_q & en_cipher;
`else
    logic unused_decrypt;
    assign unused_decrypt = decrypt_i;
    assign input_mode_o   = 1'b0;
`endif

    assign round_o            = computing ? ROUND_W'(cnt) : '0;
    assign bypass_xor_begin_o = xor_begin;
    assign bypass_xor_end_o   = xor_end;
    assign en_reg_cipher_o    = en_cipher;
    assign cipher_valid_o     = cipher_valid_q;
    assign busy_o             = (state_q != StIdle);

endmodule

// File: tb/tb_ascon_ctrl_fsm_param.sv
// Bench for ascon_ctrl_fsm_param: three parameter sets, cycle-exact expectations from phase schedules.
module tb_ascon_ctrl_fsm_param;

`ifdef ASCON_DECRYPT_EN
    localparam bit DecEn = 1'b1;
`else
    localparam bit DecEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetb, start, ad_empty, decrypt, data_valid, last;
    int   sel;
    int   checks = 0;
    int   errors = 0;
    logic cv_pending;

    logic [17:0] obs [3];

    // Instance 0: defaults; 1: Ascon-128a style PB=8; 2: single-round phases.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned PaT = (g == 2) ? 1 : 12;
        localparam int unsigned PbT = (g == 0) ? 6 : ((g == 1) ? 8 : 1);
        logic       rdy, ia, ib, es, ec, cv, et, im, bsy, en;
        logic [3:0] rnd;
        logic [1:0] xb, xe;

        ascon_ctrl_fsm_param #(
            .PA_ROUNDS (PaT),
            .PB_ROUNDS (PbT),
            .ROUND_W   (4)
        ) u_dut (
            .clock_i            (clk),
            .resetb_i           (resetb),
            .start_i            (start & (sel == g)),
            .ad_empty_i         (ad_empty),
            .decrypt_i          (decrypt),
            .data_valid_i       (data_valid & (sel == g)),
            .last_i             (last),
            .data_ready_o       (rdy),
            .round_o            (rnd),
            .init_a_o           (ia),
            .init_b_o           (ib),
            .en_reg_state_o     (es),
            .bypass_xor_begin_o (xb),
            .bypass_xor_end_o   (xe),
            .en_reg_cipher_o    (ec),
            .cipher_valid_o     (cv),
            .en_reg_tag_o       (et),
            .input_mode_o       (im),
            .busy_o             (bsy),
            .end_o              (en)
        );

        assign obs[g] = {rdy, rnd, ia, ib, es, xb, xe, ec, cv, et, im, bsy, en};
    end

    function automatic int pa_of(input int s);
        return (s == 2) ? 1 : 12;
    endfunction

    function automatic int pb_of(input int s);
        return (s == 0) ? 6 : ((s == 1) ? 8 : 1);
    endfunction

    task automatic check(input logic [17:0] exp, input string tag);
        checks++;
        assert (obs[sel] === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed %h expected %h", tag, sel, obs[sel], exp);
        end
    endtask

    // One cycle: sample at negedge against the expected fields; cipher_valid follows capture by one.
    task automatic step(input logic rdy, input int rnd, input logic ia, input logic ib,
                        input logic es, input logic [1:0] xb, input logic [1:0] xe,
                        input logic ec, input logic et, input logic im, input logic bsy,
                        input logic en, input string tag);
        logic [17:0] exp;
        @(negedge clk);
        exp = {rdy, 4'(rnd), ia, ib, es, xb, xe, ec, cv_pending, et, im, bsy, en};
        check(exp, tag);
        cv_pending = ec;
    endtask

    task automatic noise();
        start      = 1'($urandom);
        data_valid = 1'($urandom);
        last       = 1'($urandom);
        ad_empty   = 1'($urandom);
        decrypt    = 1'($urandom);
    endtask

    task automatic wait_phase(input logic lst);
        int gap;
        gap = $urandom_range(0, 3);
        for (int k = 0; k <= gap; k++) begin
            step(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, "wait");
            start      = 1'($urandom);
            data_valid = (k == gap);
            last       = (k == gap) ? lst : 1'($urandom);
        end
    endtask

    task automatic run_msg(input logic ade, input int nda, input int ntc, input logic dec,
                           input int abort_at);
        int pa, pb;
        logic im_exp;
        pa = pa_of(sel);
        pb = pb_of(sel);
        im_exp = dec & DecEn;

        step(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, "idle");
        start      = 1'b1;
        ad_empty   = ade;
        decrypt    = dec;
        data_valid = 1'($urandom);
        last       = 1'($urandom);

        for (int i = 0; i < pa; i++) begin
            step(0, 12 - pa + i, (i == 0), (i != 0), 1, 2'b00,
                 (i == pa - 1) ? (ade ? 2'b11 : 2'b01) : 2'b00, 0, 0, 0, 1, 0, "init");
            noise();
        end

        if (!ade) begin
            for (int b = 0; b < nda; b++) begin
                wait_phase(b == nda - 1);
                for (int i = 0; i < pb; i++) begin
                    step(0, 12 - pb + i, 0, 1, 1, (i == 0) ? 2'b01 : 2'b00,
                         (i == pb - 1 && b == nda - 1) ? 2'b10 : 2'b00, 0, 0, 0, 1, 0, "da");
                    if (i == abort_at) begin
                        #1 resetb = 1'b0;
                        #1 checks++;
                        assert (obs[sel] === 18'h0) else begin
                            errors++;
                            $error("FAIL abort_reset dut%0d observed %h expected %h",
                                   sel, obs[sel], 18'h0);
                        end
                        cv_pending = 1'b0;
                        start      = 1'b0;
                        data_valid = 1'b0;
                        @(posedge clk);
                        #2 resetb = 1'b1;
                        return;
                    end
                    noise();
                end
            end
        end

        for (int b = 0; b < ntc; b++) begin
            wait_phase(b == ntc - 1);
            if (b != ntc - 1) begin
                for (int i = 0; i < pb; i++) begin
                    step(0, 12 - pb + i, 0, 1, 1, (i == 0) ? 2'b01 : 2'b00, 2'b00,
                         (i == 0), 0, (i == 0) & im_exp, 1, 0, "tc");
                    noise();
                end
            end else begin
                for (int i = 0; i < pa; i++) begin
                    step(0, 12 - pa + i, 0, 1, 1, (i == 0) ? 2'b11 : 2'b00,
                         (i == pa - 1) ? 2'b01 : 2'b00, (i == 0), (i == pa - 1),
                         (i == 0) & im_exp, 1, 0, "final");
                    noise();
                end
            end
        end

        step(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1, "done");
        start      = 1'b0;
        data_valid = 1'($urandom);
    endtask

    task automatic run_random(input int n);
        logic ade;
        for (int m = 0; m < n; m++) begin
            ade = 1'($urandom);
            run_msg(ade, ade ? 0 : $urandom_range(1, 3), $urandom_range(1, 3),
                    1'($urandom), -1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb     = 1'b0;
        start      = 1'b0;
        ad_empty   = 1'b0;
        decrypt    = 1'b0;
        data_valid = 1'b0;
        last       = 1'b0;
        sel        = 0;
        cv_pending = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            check(18'h0, "reset");
        end
        resetb = 1'b1;

        sel = 0;
        run_msg(1'b0, 1, 2, 1'b1, -1);
        run_msg(1'b1, 0, 2, 1'b0, -1);
        run_msg(1'b0, 2, 1, 1'b1, 3);
        run_msg(1'b0, 1, 2, 1'b0, -1);
        run_random(6);

        sel = 1;
        run_msg(1'b0, 2, 2, 1'b1, -1);
        run_random(4);

        sel = 2;
        run_msg(1'b0, 1, 2, 1'b1, -1);
        run_msg(1'b1, 0, 1, 1'b1, -1);
        run_random(6);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
